icache_fetch: RTL and testbench

- Direct-mapped instruction cache directly upstream of the instruction unit.
- Serves the 32-bit fetch window starting at a halfword-aligned pc, combinationally on a hit, so the instruction unit can decode and step pc in the same cycle.
- On a miss it refills a whole line from the memory unit through a word-stream request/ready handshake.
- Handles RVC: a fetch may straddle two words or two lines.

---
 rtl/icache_fetch.sv | 162 ++++++++++++++++
 tb/tb_icache_fetch.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_fetch.sv
// Direct-mapped instruction cache: combinational hit path for a halfword-aligned
// 32-bit fetch window (RVC straddles across words/lines), line refill over a word stream.
module icache_fetch #(
    parameter int unsigned INDEX_BIT  = 4,
    parameter int unsigned OFFSET_BIT = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] pc_in,
    input  logic        inst_req,
    output logic        inst_ready,
    output logic [31:0] inst,
    output logic        mem_busy,
    output logic        fill_req,
    output logic [31:0] fill_addr,
    input  logic        fill_ready,
    input  logic [31:0] fill_data
);

    localparam int unsigned LINES      = 1 << INDEX_BIT;
    localparam int unsigned LINE_WORDS = 1 << (OFFSET_BIT - 2);
    localparam int unsigned WORD_BIT   = OFFSET_BIT - 2;
    localparam int unsigned TAG_BIT    = 32 - INDEX_BIT - OFFSET_BIT;
    localparam logic [31:0] LINE_MASK  = ~((32'd1 << OFFSET_BIT) - 32'd1);

    typedef enum logic {
        ST_IDLE,
        ST_FILL
    } state_e;

    state_e                 state_q, state_d;
    logic [LINES-1:0]       valid_q, valid_d;
    logic [TAG_BIT-1:0]     tag_q  [LINES];
    logic [31:0]            data_q [LINES][LINE_WORDS];
    logic [WORD_BIT-1:0]    cnt_q, cnt_d;
    logic                   fill_req_q, fill_req_d;
    logic [31:0]            fill_addr_q, fill_addr_d;
    logic                   mem_busy_q, mem_busy_d;
    logic [TAG_BIT-1:0]     miss_tag_q, miss_tag_d;
    logic [INDEX_BIT-1:0]   miss_idx_q, miss_idx_d;
    logic                   wr_en_c, tag_we_c;

    // Lookup: lo half at pc, hi half at pc+2 (same word, next word or next line)
    logic [31:0]          hi_pc_c, miss_addr_c;
    logic [TAG_BIT-1:0]   lo_tag_c, hi_tag_c;
    logic [INDEX_BIT-1:0] lo_idx_c, hi_idx_c;
    logic [WORD_BIT-1:0]  lo_word_c, hi_word_c;
    logic [31:0]          lo_data_c, hi_data_c;
    logic [15:0]          lo_half_c, hi_half_c;
    logic                 lo_hit_c, hi_hit_c, compressed_c;

    assign hi_pc_c   = pc_in + 32'd2;
    assign lo_tag_c  = pc_in[31 -: TAG_BIT];
    assign hi_tag_c  = hi_pc_c[31 -: TAG_BIT];
    assign lo_idx_c  = pc_in[OFFSET_BIT +: INDEX_BIT];
    assign hi_idx_c  = hi_pc_c[OFFSET_BIT +: INDEX_BIT];
    assign lo_word_c = pc_in[2 +: WORD_BIT];
    assign hi_word_c = hi_pc_c[2 +: WORD_BIT];
    assign lo_data_c = data_q[lo_idx_c][lo_word_c];
    assign hi_data_c = data_q[hi_idx_c][hi_word_c];
    assign lo_half_c = pc_in[1]   ? lo_data_c[31:16] : lo_data_c[15:0];
    assign hi_half_c = hi_pc_c[1] ? hi_data_c[31:16] : hi_data_c[15:0];
    assign lo_hit_c  = valid_q[lo_idx_c] && (tag_q[lo_idx_c] == lo_tag_c);
    assign hi_hit_c  = valid_q[hi_idx_c] && (tag_q[hi_idx_c] == hi_tag_c);
    assign compressed_c = (lo_half_c[1:0] != 2'b11);
    assign miss_addr_c  = lo_hit_c ? hi_pc_c : pc_in;

    assign inst_ready = rst_in && inst_req && lo_hit_c && (compressed_c || hi_hit_c)
                        && (state_q == ST_IDLE);
    assign inst       = {hi_half_c, lo_half_c};

    assign mem_busy  = mem_busy_q;
    assign fill_req  = fill_req_q;
    assign fill_addr = fill_addr_q;

    // State register
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q <= ST_IDLE;
        end else if (rdy_in) begin
            state_q <= state_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (rdy_in && inst_req && !inst_ready) state_d = ST_FILL;
            ST_FILL: if (rdy_in && fill_ready && (cnt_q == WORD_BIT'(LINE_WORDS - 1)))
                         state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs, fill counter and array write controls
    always_comb begin
        fill_req_d  = fill_req_q;
        fill_addr_d = fill_addr_q;
        cnt_d       = cnt_q;
        miss_tag_d  = miss_tag_q;
        miss_idx_d  = miss_idx_q;
        valid_d     = valid_q;
        wr_en_c     = 1'b0;
        tag_we_c    = 1'b0;
        mem_busy_d  = (state_d == ST_FILL);
        case (state_q)
            ST_IDLE: begin
                if (state_d == ST_FILL) begin
                    fill_req_d  = 1'b1;
                    fill_addr_d = miss_addr_c & LINE_MASK;
                    cnt_d       = '0;
                    miss_tag_d  = miss_addr_c[31 -: TAG_BIT];
                    miss_idx_d  = miss_addr_c[OFFSET_BIT +: INDEX_BIT];
                end
            end
            ST_FILL: begin
                if (rdy_in && fill_ready) begin
                    wr_en_c     = 1'b1;
                    cnt_d       = cnt_q + WORD_BIT'(1);
                    fill_addr_d = fill_addr_q + 32'd4;
                    if (state_d == ST_IDLE) begin
                        tag_we_c            = 1'b1;
                        valid_d[miss_idx_q] = 1'b1;
                        fill_req_d          = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            valid_q     <= '0;
            cnt_q       <= '0;
            fill_req_q  <= 1'b0;
            fill_addr_q <= 32'd0;
            mem_busy_q  <= 1'b0;
            miss_tag_q  <= '0;
            miss_idx_q  <= '0;
        end else if (rdy_in) begin
            valid_q     <= valid_d;
            cnt_q       <= cnt_d;
            fill_req_q  <= fill_req_d;
            fill_addr_q <= fill_addr_d;
            mem_busy_q  <= mem_busy_d;
            miss_tag_q  <= miss_tag_d;
            miss_idx_q  <= miss_idx_d;
        end
    end

    // Tag and data storage carry no reset; validity lives in valid_q
    always_ff @(posedge clk_in) begin
        if (rst_in && wr_en_c) begin
            data_q[miss_idx_q][cnt_q] <= fill_data;
            if (tag_we_c) tag_q[miss_idx_q] <= miss_tag_q;
        end
    end

endmodule

// File: tb/tb_icache_fetch.sv
// Bench for icache_fetch: memory responder, line-residency reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_icache_fetch;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, inst_req, fill_ready;
    logic [31:0] pc_in, fill_data;
    logic        inst_ready, mem_busy, fill_req;
    logic [31:0] inst, fill_addr;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          scen    = 0;
    int unsigned mem_pct = 100;
    bit          chk_en  = 1'b0;
    bit          prev_req;
    logic [31:0] fills_q[$];

    // Reference model: which line address each set holds, and the pending refill
    logic        m_valid [16];
    logic [31:0] m_line  [16];
    logic        m_busy = 1'b0;
    logic [31:0] m_base = 32'd0;
    int          m_cnt  = 0;

    icache_fetch #(.INDEX_BIT(4), .OFFSET_BIT(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .pc_in(pc_in),
        .inst_req(inst_req), .inst_ready(inst_ready), .inst(inst), .mem_busy(mem_busy),
        .fill_req(fill_req), .fill_addr(fill_addr), .fill_ready(fill_ready),
        .fill_data(fill_data)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    function automatic logic [31:0] mem_word(logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (scen != 0) begin
            case (w)
                32'h0:  return 32'h00000013;
                32'h4:  return 32'h00A00093;
                32'h8:  return 32'h00B00113;
                32'hC:  return (scen == 2) ? 32'h45050001 :
                               (scen == 3) ? 32'h00931234 : 32'h002081B3;
                32'h10: if (scen == 3) return 32'hABCD7777;
                default: ;
            endcase
        end
        return (w * 32'h9E3779B1) ^ (w >> 11) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [15:0] mem_half(logic [31:0] a);
        logic [31:0] w;
        w = mem_word(a);
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    function automatic logic resident(logic [31:0] a);
        return m_valid[a[7:4]] && (m_line[a[7:4]] == {a[31:4], 4'h0});
    endfunction

    function automatic logic model_ready();
        logic [15:0] lo;
        lo = mem_half(pc_in);
        return rst_in && inst_req && !m_busy && resident(pc_in)
               && ((lo[1:0] != 2'b11) || resident(pc_in + 32'd2));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on the same edge the DUT samples
    always @(posedge clk_in) begin
        if (!rst_in) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
            for (int i = 0; i < 16; i++) m_valid[i] <= 1'b0;
        end else if (rdy_in) begin
            if (!m_busy) begin
                if (inst_req && !model_ready()) begin
                    m_busy <= 1'b1;
                    m_cnt  <= 0;
                    m_base <= resident(pc_in) ? ((pc_in + 32'd2) & 32'hFFFFFFF0)
                                              : (pc_in & 32'hFFFFFFF0);
                end
            end else if (fill_ready) begin
                if (m_cnt == 3) begin
                    m_valid[m_base[7:4]] <= 1'b1;
                    m_line[m_base[7:4]]  <= m_base;
                    m_busy <= 1'b0;
                    m_cnt  <= 0;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk_in) begin
        if (chk_en) begin
            chk("inst_ready", 32'(inst_ready), 32'(model_ready()));
            if (model_ready()) begin
                chk("inst_lo", 32'(inst[15:0]), 32'(mem_half(pc_in)));
                if (inst[1:0] == 2'b11)
                    chk("inst_hi", 32'(inst[31:16]), 32'(mem_half(pc_in + 32'd2)));
            end
            chk("fill_req", 32'(fill_req), 32'(m_busy));
            chk("mem_busy", 32'(mem_busy), 32'(m_busy));
            if (m_busy) chk("fill_addr", fill_addr, m_base + 32'(m_cnt * 4));
        end
    end

    // One clock: advance past the edge, then let the memory answer the visible request
    task automatic cyc();
        @(posedge clk_in);
        #1;
        fill_ready = fill_req && ($urandom_range(99) < mem_pct);
        fill_data  = fill_ready ? mem_word(fill_addr) : $urandom;
    endtask

    task automatic do_reset(input int s);
        rst_in = 1'b0; rdy_in = 1'b1; inst_req = 1'b0; pc_in = 32'd0;
        fill_ready = 1'b0; fill_data = 32'd0;
        cyc();
        scen   = s;
        chk_en = 1'b1;
        cyc();
        fill_ready = 1'b0;
        rst_in = 1'b1;
    endtask

    task automatic wait_hit(output int n);
        n = 0;
        prev_req = 1'b0;
        @(negedge clk_in);
        while (inst_ready !== 1'b1 && n < 40) begin
            cyc();
            @(negedge clk_in);
            if (fill_req && !prev_req) fills_q.push_back(fill_addr);
            prev_req = fill_req;
            n++;
        end
        chk("hit_timeout", 32'(inst_ready), 32'd1);
    endtask

    initial begin
        int n;
        logic [31:0] base;

        // Cold miss on line 0
        do_reset(1);
        pc_in = 32'h0; inst_req = 1'b1;
        @(negedge clk_in);
        chk("cold_miss", 32'(inst_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            @(negedge clk_in);
            chk("cold_fill_addr", fill_addr, 32'(i * 4));
            chk("cold_busy", 32'(mem_busy), 32'd1);
        end
        cyc();
        @(negedge clk_in);
        chk("cold_ready", 32'(inst_ready), 32'd1);
        chk("cold_inst", inst, 32'h00000013);
        chk("cold_idle", 32'(mem_busy), 32'd0);

        // Hit in the freshly filled line
        #1; pc_in = 32'h8; #1;
        chk("hit_ready", 32'(inst_ready), 32'd1);
        chk("hit_inst", inst, 32'h00B00113);
        cyc();
        @(negedge clk_in);
        chk("hit_noreq", 32'(fill_req), 32'd0);

        // Compressed at line edge: next line never needed
        do_reset(2);
        pc_in = 32'hE; inst_req = 1'b1; fills_q.delete();
        wait_hit(n);
        chk("cedge_latency", 32'(n), 32'd5);
        chk("cedge_lo", 32'(inst[15:0]), 32'h4505);
        chk("cedge_fills", 32'(fills_q.size()), 32'd1);
        cyc();
        @(negedge clk_in);
        chk("cedge_nofill", 32'(fill_req), 32'd0);

        // 32-bit straddle: two sequential fills
        do_reset(3);
        pc_in = 32'hE; inst_req = 1'b1; fills_q.delete();
        wait_hit(n);
        chk("strad_latency", 32'(n), 32'd10);
        chk("strad_fills", 32'(fills_q.size()), 32'd2);
        if (fills_q.size() == 2) begin
            chk("strad_fill0", fills_q[0], 32'h0);
            chk("strad_fill1", fills_q[1], 32'h10);
        end
        chk("strad_inst", inst, 32'h77770093);

        // Backpressure: rdy_in low for three cycles with fill_ready pulsing garbage
        do_reset(1);
        pc_in = 32'h0; inst_req = 1'b1;
        cyc(); cyc(); cyc();
        for (int k = 0; k < 3; k++) begin
            rdy_in = 1'b0; fill_data = 32'hDEADBEEF;
            @(negedge clk_in);
            chk("bp_addr_hold", fill_addr, 32'h8);
            chk("bp_busy_hold", 32'(mem_busy), 32'd1);
            cyc();
        end
        rdy_in = 1'b1;
        wait_hit(n);
        chk("bp_latency", 32'(n), 32'd2);
        chk("bp_inst0", inst, 32'h00000013);
        #1; pc_in = 32'h8; #1;
        chk("bp_inst8", inst, 32'h00B00113);
        pc_in = 32'hC; #1;
        chk("bp_instC", inst, 32'h002081B3);

        // Reset after two of four words
        do_reset(1);
        pc_in = 32'h0; inst_req = 1'b1;
        cyc(); cyc(); cyc();
        rst_in = 1'b0; fill_ready = 1'b0;
        @(negedge clk_in);
        cyc();
        @(negedge clk_in);
        chk("rst_req", 32'(fill_req), 32'd0);
        chk("rst_busy", 32'(mem_busy), 32'd0);
        chk("rst_ready", 32'(inst_ready), 32'd0);
        #1; rst_in = 1'b1; #1;
        chk("rst_miss", 32'(inst_ready), 32'd0);
        cyc();
        @(negedge clk_in);
        chk("rst_restart_req", 32'(fill_req), 32'd1);
        chk("rst_restart_addr", fill_addr, 32'h0);
        cyc();
        wait_hit(n);
        chk("rst_refill_inst", inst, 32'h00000013);

        // Randomized traffic over aliasing sets and the 2^32 wrap
        do_reset(0);
        mem_pct = 60;
        for (int c = 0; c < 4000; c++) begin
            cyc();
            rst_in   = ($urandom_range(499) != 0);
            rdy_in   = ($urandom_range(9) != 0);
            inst_req = ($urandom_range(4) != 0);
            if (!rst_in) fill_ready = 1'b0;
            if ($urandom_range(1) == 0) begin
                case ($urandom_range(2))
                    0:       base = 32'h00000000;
                    1:       base = 32'h00000100;
                    default: base = 32'hFFFFFF80;
                endcase
                pc_in = base + 32'($urandom_range(127)) * 32'd2;
            end
        end
        @(negedge clk_in);
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
